// File: rtl/lc3_pkg.sv
// lc3_pkg: shared constants for the LC-3 memory-mapped console.
// Holds the register map addresses and the KBSR/DSR status bit positions.
package lc3_pkg;

    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;
    localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

    localparam int SR_READY_BIT = 15;
    localparam int SR_IE_BIT    = 14;

endpackage

// File: rtl/lc3_sync_fifo.sv
// lc3_sync_fifo: single-clock FIFO with first-word-fall-through head.
// Ports:
//   clk, rst      clock, synchronous active-high reset (flushes the FIFO)
//   push, wdata   write request and data; ignored while full
//   pop           read request; ignored while empty
//   head          oldest entry (undefined content when empty)
//   full, empty   status
module lc3_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra MSB so full and empty are distinguishable
    // when the index bits match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lc3_mmio_console.sv
// lc3_mmio_console: memory-mapped keyboard/display/machine-control slave
// on the LC-3 data-memory port.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_addr/re/we/wdata     CPU access; re and we are single-cycle strobes
//   mem_rdata, mmio_hit      combinational read data and map hit
//   kb_valid/kb_data/kb_ready    keyboard source handshake (RX FIFO)
//   disp_valid/disp_data/disp_ready  display sink handshake
//   kb_irq                   registered KBSR[15] & KBSR[14]
//   run                      MCR[15]; core halts when 0
module lc3_mmio_console
    import lc3_pkg::*;
#(
    parameter int KB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mem_addr,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mmio_hit,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        kb_irq,
    output logic        run
);

    logic       hit_kbsr, hit_kbdr, hit_dsr, hit_ddr, hit_mcr;
    logic       ie;
    logic       fifo_full, fifo_empty, fifo_pop;
    logic [7:0] fifo_head;
    logic       unused_wdata;

    assign unused_wdata = ^mem_wdata[13:8];

    assign hit_kbsr = (mem_addr == ADDR_KBSR);
    assign hit_kbdr = (mem_addr == ADDR_KBDR);
    assign hit_dsr  = (mem_addr == ADDR_DSR);
    assign hit_ddr  = (mem_addr == ADDR_DDR);
    assign hit_mcr  = (mem_addr == ADDR_MCR);
    assign mmio_hit = hit_kbsr | hit_kbdr | hit_dsr | hit_ddr | hit_mcr;

    // A simultaneous write strobe turns the access into a write, so no pop.
    assign fifo_pop = mem_re && !mem_we && hit_kbdr && !fifo_empty;
    assign kb_ready = !fifo_full;

    lc3_sync_fifo #(
        .WIDTH (8),
        .DEPTH (KB_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (kb_valid),
        .wdata (kb_data),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        mem_rdata = 16'h0000;
        if (hit_kbsr) begin
            mem_rdata[SR_READY_BIT] = !fifo_empty;
            mem_rdata[SR_IE_BIT]    = ie;
        end else if (hit_kbdr) begin
            if (!fifo_empty) mem_rdata[7:0] = fifo_head;
        end else if (hit_dsr) begin
            mem_rdata[SR_READY_BIT] = !disp_valid;
        end else if (hit_mcr) begin
            mem_rdata[15] = run;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ie         <= 1'b0;
            run        <= 1'b1;
            disp_valid <= 1'b0;
            disp_data  <= 8'h00;
            kb_irq     <= 1'b0;
        end else begin
            kb_irq <= !fifo_empty && ie;

            if (mem_we && hit_kbsr) ie  <= mem_wdata[SR_IE_BIT];
            if (mem_we && hit_mcr)  run <= mem_wdata[15];

            // A completing handshake takes priority; a DDR write is only
            // accepted when nothing is pending.
            if (disp_valid && disp_ready) begin
                disp_valid <= 1'b0;
            end else if (mem_we && hit_ddr && !disp_valid) begin
                disp_data  <= mem_wdata[7:0];
                disp_valid <= 1'b1;
            end
        end
    end

endmodule
